// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack memory port and
// feeds a registered IF/ID slot, with branch flush, decode freeze and a skid entry.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        valid,
    output logic [1:0]  o_dbg_state
);

    // Handshake: imem_addr is held while imem_req=1 until imem_ack; a redirect
    // never withdraws an outstanding request, the returning word is discarded.
    // o_dbg_state encoding: IDLE=0, REQ=1, FLUSH=2, WAIT=3.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_FLUSH = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic [31:0] r_addr;
    logic [31:0] r_next;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_inst;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_valid;

    logic        w_slot_free;
    logic [31:0] w_addr_inc;

    assign w_slot_free = !r_valid || !freeze;
    assign w_addr_inc  = r_addr + 32'd4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_req       <= 1'b0;
            r_addr      <= RESET_PC;
            r_next      <= 32'd0;
            r_skid_pc   <= 32'd0;
            r_skid_inst <= 32'd0;
            r_pc        <= 32'd0;
            r_inst      <= 32'd0;
            r_valid     <= 1'b0;
        end else begin
            // Slot defaults to a bubble unless frozen with live contents; loads below override.
            if (branch_taken || !(freeze && r_valid)) begin
                r_valid <= 1'b0;
                r_inst  <= 32'd0;
            end

            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b1;
                    if (branch_taken) begin
                        r_addr <= branch_addr;
                    end
                end

                S_REQ: begin
                    if (imem_ack) begin
                        if (branch_taken) begin
                            r_addr <= branch_addr;
                        end else if (w_slot_free) begin
                            r_pc    <= w_addr_inc;
                            r_inst  <= imem_data;
                            r_valid <= 1'b1;
                            r_addr  <= w_addr_inc;
                        end else begin
                            r_skid_pc   <= w_addr_inc;
                            r_skid_inst <= imem_data;
                            r_addr      <= w_addr_inc;
                            r_state     <= S_WAIT;
                            r_req       <= 1'b0;
                        end
                    end else if (branch_taken) begin
                        r_next  <= branch_addr;
                        r_state <= S_FLUSH;
                    end
                end

                S_FLUSH: begin
                    if (imem_ack) begin
                        r_addr  <= branch_taken ? branch_addr : r_next;
                        r_state <= S_REQ;
                    end else if (branch_taken) begin
                        r_next <= branch_addr;
                    end
                end

                S_WAIT: begin
                    if (branch_taken) begin
                        r_addr  <= branch_addr;
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                    end else if (!freeze) begin
                        r_pc    <= r_skid_pc;
                        r_inst  <= r_skid_inst;
                        r_valid <= 1'b1;
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign pc          = r_pc;
    assign inst        = r_inst;
    assign valid       = r_valid;
    assign o_dbg_state = r_state;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage pipeline: owns the program counter, fetches from a variable-latency instruction memory over a req/ack handshake, and presents `{pc, inst, valid}` in a registered IF/ID slot directly to the decode stage. Handles branch redirects from EX, with flush, and freeze, a hazard stall from the hazard unit, using a one-entry skid buffer so no fetched instruction is lost or duplicated.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `freeze`  in  1  decode stalled; the IF/ID slot must hold its contents
- `branch_taken`  in  1  redirect request from EX; flushes fetch
- `branch_addr`  in  32  redirect target, sampled when `branch_taken`=1
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address; stable while `imem_req`=1 until ack
- `imem_ack`  in  1  read data valid this cycle; legal only while `imem_req`=1
- `imem_data`  in  32  instruction word, valid with `imem_ack`
- `pc`  out  32  fetched address + 4; drives decode `pcIn`
- `inst`  out  32  fetched instruction word
- `valid`  out  1  IF/ID slot holds a real instruction

## Operation
- Registers: `addr_q` (current or next fetch address), `next_q` (pending redirect target), `skid_q` (instruction and pc), output slot (`pc`, `inst`, `valid`), and FSM state.
- `imem_addr` = `addr_q`. `imem_req` = 1 in REQ and FLUSH, 0 otherwise.
- `slot_free` = !`valid` | !`freeze`.
- **IDLE** (reset state): goes to REQ on the next edge. If `branch_taken`=1, `addr_q` <= `branch_addr`.
- **REQ**:
  - ack & `branch_taken`: drop the data; `addr_q` <= `branch_addr`; stay in REQ.
  - ack & `slot_free`: slot <= {`addr_q`+4, `imem_data`, 1}; `addr_q` += 4.
  - ack & !`slot_free`: `skid_q` <= {`addr_q`+4, `imem_data`}; `addr_q` += 4; go to WAIT.
  - !ack & `branch_taken`: `next_q` <= `branch_addr`; go to FLUSH. The request stays asserted at the old address.
- **FLUSH**: keeps the request up at `addr_q`.
  - On ack: discard the data; `addr_q` <= `next_q`; go to REQ.
  - `branch_taken` in FLUSH overwrites `next_q` (latest wins). If it coincides with ack, `addr_q` <= `branch_addr`.
- **WAIT**:
  - `branch_taken`: drop the skid; `addr_q` <= `branch_addr`; go to REQ.
  - else !`freeze`: slot <= skid with valid 1; go to REQ.
- Output slot priority each edge:
  1. `branch_taken` → `valid` <= 0, `inst` <= 0. Flush beats freeze.
  2. `freeze` & `valid` → hold.
  3. Otherwise load per the FSM above. If nothing is loaded, `valid` <= 0 and `inst` <= 0 (bubble; opcode 0 = NOP).
- Address arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0. There is no alignment check.

## Timing
- Reset values (asynchronous, `rst`=0): state IDLE, `addr_q`=`RESET_PC`, `next_q`=0, `skid_q`=0, `pc`=0, `inst`=0, `valid`=0, `imem_req`=0.
- The first request is asserted on the first cycle after the first edge following reset deassertion.
- Combinational ack (ack in the same cycle as req): throughput is 1 instruction/cycle. The slot is loaded on the ack edge, so latency is 1 cycle from ack to `valid`.
- `imem_addr` must not change while `imem_req`=1 and no ack has occurred. Redirects never retract an outstanding request.
- Freeze: the slot holds for any number of cycles. At most one extra instruction is buffered in skid. No request is issued in WAIT.
- Reset mid-request: everything returns to reset values immediately. A late ack arriving after reset is ignored, because IDLE has no request.

## Test plan
- `imem_ack` tied to 1, no branch/freeze → `imem_addr` 0,4,8,…; `valid` rises 1 cycle after the first req; `pc`/`inst` pairs 4/mem[0], 8/mem[1], one per cycle.
- Freeze asserted for 3 cycles while `valid`=1, ack=1 → slot holds the same `pc`/`inst`; one word lands in skid; `imem_req`=0 for the remaining frozen cycles; after release the skid emerges next with no gap or duplicate.
- Memory latency 3 cycles; `branch_taken` with `branch_addr`=0x40 in the 2nd wait cycle → `imem_addr` stays at the old address until ack; that data is discarded; the next request goes to 0x40; `valid`=0 meanwhile.
- `branch_taken` coincident with `freeze`=1 and `valid`=1 → `valid`=0 and `inst`=0 the next cycle; the following fetch goes to the target.
- Two branches (0x80, then 0xC0) during one FLUSH → the fetch after the ack goes to 0xC0.
- `rst` pulled low with a request outstanding and an ack arriving the cycle after → all outputs at reset values; the first post-reset request goes to `RESET_PC`.
